// File: rtl/bp_update_sched.sv
// Port scheduler for one single-ported branch-predictor counter table: lookups win the
// port, queued updates run as saturating read-modify-writes. Optional sweep: BP_INIT_SWEEP_EN.
module bp_update_sched #(
   parameter int IndexBits = 10,
   parameter int CtrBits   = 2,
   parameter int FifoDepth = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_bp_i,
   input  logic                 lookup_valid_i,
   input  logic [IndexBits-1:0] lookup_index_i,
   output logic                 pred_valid_o,
   output logic                 pred_taken_o,
   input  logic                 upd_valid_i,
   input  logic [IndexBits-1:0] upd_index_i,
   input  logic                 upd_taken_i,
   output logic                 upd_ready_o,
   output logic                 busy_o,
   output logic                 tbl_req_o,
   output logic                 tbl_we_o,
   output logic [IndexBits-1:0] tbl_addr_o,
   output logic [CtrBits-1:0]   tbl_wdata_o,
   input  logic [CtrBits-1:0]   tbl_rdata_i
);

   localparam int PtrBits = $clog2(FifoDepth);
   localparam logic [CtrBits-1:0] CTR_MAX  = {CtrBits{1'b1}};
   localparam logic [CtrBits-1:0] CTR_ZERO = {CtrBits{1'b0}};
   localparam logic [CtrBits-1:0] CTR_ONE  = {{(CtrBits-1){1'b0}}, 1'b1};
   localparam logic [PtrBits:0]   FIFO_FULL = FifoDepth[PtrBits:0];
   localparam logic [IndexBits-1:0] IDX_ZERO = {IndexBits{1'b0}};

   typedef enum logic [1:0] {
`ifdef BP_INIT_SWEEP_EN
      ST_INIT = 2'd3,
`endif
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2
   } state_t;

`ifdef BP_INIT_SWEEP_EN
   localparam logic [CtrBits-1:0]   INIT_VAL   = {1'b0, {(CtrBits-1){1'b1}}};
   localparam logic [IndexBits-1:0] IDX_LAST   = {IndexBits{1'b1}};
   localparam logic [IndexBits-1:0] IDX_ONE    = {{(IndexBits-1){1'b0}}, 1'b1};
   localparam state_t               RESTART_ST = ST_INIT;
`else
   localparam state_t               RESTART_ST = ST_IDLE;
`endif

   function automatic logic [CtrBits-1:0] sat_update(input logic [CtrBits-1:0] ctr,
                                                     input logic taken);
      if (taken) begin
         return (ctr == CTR_MAX) ? ctr : ctr + CTR_ONE;
      end else begin
         return (ctr == CTR_ZERO) ? ctr : ctr - CTR_ONE;
      end
   endfunction

   state_t                 state_r, state_nxt_s;
   logic [IndexBits-1:0]   idx_r;
   logic                   taken_r;
   logic [CtrBits-1:0]     new_r, new_nxt_s, upd_val_s;
   logic                   pred_valid_r;
   logic                   grant_s, pop_s, push_s, empty_s, full_s, is_init_s;
   logic                   tbl_req_s, tbl_we_s;
   logic [IndexBits-1:0]   tbl_addr_s;
   logic [CtrBits-1:0]     tbl_wdata_s;
   logic [IndexBits:0]     fifo_r [FifoDepth];
   logic [IndexBits:0]     head_s;
   logic [PtrBits-1:0]     wr_ptr_r, rd_ptr_r;
   logic [PtrBits:0]       count_r;

`ifdef BP_INIT_SWEEP_EN
   logic [IndexBits-1:0]   sweep_r, sweep_nxt_s;
   assign is_init_s = (state_r == ST_INIT);
`else
   assign is_init_s = 1'b0;
`endif

   assign empty_s     = (count_r == {(PtrBits+1){1'b0}});
   assign full_s      = (count_r == FIFO_FULL);
   assign grant_s     = lookup_valid_i & ~is_init_s;
   assign upd_ready_o = ~full_s & ~is_init_s;
   assign push_s      = upd_valid_i & upd_ready_o & ~flush_bp_i;
   assign head_s      = fifo_r[rd_ptr_r];
   assign upd_val_s   = sat_update(tbl_rdata_i, taken_r);
   assign busy_o      = is_init_s;

   // Next state and table port; a flush drops any access except a granted lookup
   always_comb begin
      state_nxt_s = state_r;
      new_nxt_s   = new_r;
      pop_s       = 1'b0;
      tbl_req_s   = 1'b0;
      tbl_we_s    = 1'b0;
      tbl_addr_s  = IDX_ZERO;
      tbl_wdata_s = CTR_ZERO;
`ifdef BP_INIT_SWEEP_EN
      sweep_nxt_s = flush_bp_i ? IDX_ZERO : sweep_r;
`endif
      case (state_r)
`ifdef BP_INIT_SWEEP_EN
         ST_INIT: begin
            if (flush_bp_i) begin
               state_nxt_s = ST_INIT;
            end else begin
               tbl_req_s   = 1'b1;
               tbl_we_s    = 1'b1;
               tbl_addr_s  = sweep_r;
               tbl_wdata_s = INIT_VAL;
               if (sweep_r == IDX_LAST) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  sweep_nxt_s = sweep_r + IDX_ONE;
               end
            end
         end
`endif
         ST_IDLE: begin
            if (grant_s) begin
               tbl_req_s  = 1'b1;
               tbl_addr_s = lookup_index_i;
            end else if (!flush_bp_i && !empty_s) begin
               pop_s       = 1'b1;
               tbl_req_s   = 1'b1;
               tbl_addr_s  = head_s[IndexBits-1:0];
               state_nxt_s = ST_RD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
            if (flush_bp_i) begin
               state_nxt_s = RESTART_ST;
            end else begin
               state_nxt_s = state_nxt_s;
            end
         end
         ST_RD: begin
            if (grant_s) begin
               tbl_req_s   = 1'b1;
               tbl_addr_s  = lookup_index_i;
               new_nxt_s   = upd_val_s;
               state_nxt_s = flush_bp_i ? RESTART_ST : ST_WR;
            end else if (flush_bp_i) begin
               state_nxt_s = RESTART_ST;
            end else begin
               tbl_req_s   = 1'b1;
               tbl_we_s    = 1'b1;
               tbl_addr_s  = idx_r;
               tbl_wdata_s = upd_val_s;
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WR: begin
            if (grant_s) begin
               tbl_req_s   = 1'b1;
               tbl_addr_s  = lookup_index_i;
               state_nxt_s = flush_bp_i ? RESTART_ST : ST_WR;
            end else if (flush_bp_i) begin
               state_nxt_s = RESTART_ST;
            end else begin
               tbl_req_s   = 1'b1;
               tbl_we_s    = 1'b1;
               tbl_addr_s  = idx_r;
               tbl_wdata_s = new_r;
               state_nxt_s = ST_IDLE;
            end
         end
         default: begin
            state_nxt_s = RESTART_ST;
         end
      endcase
   end

   // Table port is held quiet while reset is asserted
   assign tbl_req_o   = tbl_req_s & ~rst_i;
   assign tbl_we_o    = tbl_we_s & ~rst_i;
   assign tbl_addr_o  = rst_i ? IDX_ZERO : tbl_addr_s;
   assign tbl_wdata_o = rst_i ? CTR_ZERO : tbl_wdata_s;
   assign pred_taken_o = pred_valid_r & tbl_rdata_i[CtrBits-1];
   assign pred_valid_o = pred_valid_r;

   // Scheduler state, latched RMW operands and prediction-valid flag
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r      <= RESTART_ST;
         idx_r        <= IDX_ZERO;
         taken_r      <= 1'b0;
         new_r        <= CTR_ZERO;
         pred_valid_r <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         new_r        <= new_nxt_s;
         pred_valid_r <= grant_s;
         if (pop_s) begin
            idx_r   <= head_s[IndexBits-1:0];
            taken_r <= head_s[IndexBits];
         end
      end
   end

`ifdef BP_INIT_SWEEP_EN
   // Sweep address counter
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sweep_r <= IDX_ZERO;
      end else begin
         sweep_r <= sweep_nxt_s;
      end
   end
`endif

   // Update FIFO pointers and occupancy
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_r <= {PtrBits{1'b0}};
         rd_ptr_r <= {PtrBits{1'b0}};
         count_r  <= {(PtrBits+1){1'b0}};
      end else if (flush_bp_i) begin
         wr_ptr_r <= {PtrBits{1'b0}};
         rd_ptr_r <= {PtrBits{1'b0}};
         count_r  <= {(PtrBits+1){1'b0}};
      end else begin
         wr_ptr_r <= wr_ptr_r + {{(PtrBits-1){1'b0}}, push_s};
         rd_ptr_r <= rd_ptr_r + {{(PtrBits-1){1'b0}}, pop_s};
         count_r  <= count_r + {{PtrBits{1'b0}}, push_s} - {{PtrBits{1'b0}}, pop_s};
      end
   end

   // Update FIFO storage
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         fifo_r[wr_ptr_r] <= {upd_taken_i, upd_index_i};
      end
   end

endmodule

// File: tb/tb_bp_update_sched.sv
// Directed bench for bp_update_sched (IndexBits=4, CtrBits=2, FifoDepth=4) with a
// behavioural single-port table; covers both BP_INIT_SWEEP_EN builds.
module tb_bp_update_sched;
   logic       clk = 1'b0;
   logic       rst, flush, lv, uv, ut;
   logic [3:0] li, ui;
   logic       pred_valid, pred_taken, upd_ready, busy;
   logic       tbl_req, tbl_we;
   logic [3:0] tbl_addr;
   logic [1:0] tbl_wdata, tbl_rdata;
   logic [1:0] mem [16];
   int         checks = 0;
   int         errors = 0;

   bp_update_sched #(.IndexBits(4), .CtrBits(2), .FifoDepth(4)) dut (
      .clk_i(clk), .rst_i(rst), .flush_bp_i(flush),
      .lookup_valid_i(lv), .lookup_index_i(li),
      .pred_valid_o(pred_valid), .pred_taken_o(pred_taken),
      .upd_valid_i(uv), .upd_index_i(ui), .upd_taken_i(ut),
      .upd_ready_o(upd_ready), .busy_o(busy),
      .tbl_req_o(tbl_req), .tbl_we_o(tbl_we), .tbl_addr_o(tbl_addr),
      .tbl_wdata_o(tbl_wdata), .tbl_rdata_i(tbl_rdata)
   );

   always #5 clk = ~clk;

   // Single-port table model, preloaded with the weakly-not-taken value under reset
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) mem[i] <= 2'd1;
         tbl_rdata <= 2'd0;
      end else if (tbl_req) begin
         if (tbl_we) mem[tbl_addr] <= tbl_wdata;
         else tbl_rdata <= mem[tbl_addr];
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic l, input logic [3:0] lidx, input logic u,
                        input logic [3:0] uidx, input logic t, input logic f);
      @(negedge clk);
      lv = l; li = lidx; uv = u; ui = uidx; ut = t; flush = f;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   task automatic chk_rd(input string tag, input logic [3:0] a);
      check(tag, {tbl_req, tbl_we, tbl_addr}, {1'b1, 1'b0, a});
   endtask

   task automatic chk_wr(input string tag, input logic [3:0] a, input logic [1:0] d);
      check(tag, {tbl_req, tbl_we, tbl_addr, tbl_wdata}, {1'b1, 1'b1, a, d});
   endtask

   task automatic do_update(input logic [3:0] idx, input logic t, input logic [1:0] exp_w);
      drive(1'b0, 4'd0, 1'b1, idx, t, 1'b0);
      check("upd_ready", upd_ready, 1'b1);
      idle();
      chk_rd("rmw_read", idx);
      idle();
      chk_wr("rmw_write", idx, exp_w);
   endtask

   task automatic do_lookup(input logic [3:0] idx, input logic exp_t);
      drive(1'b1, idx, 1'b0, 4'd0, 1'b0, 1'b0);
      chk_rd("lookup_req", idx);
      idle();
      check("lookup_valid", pred_valid, 1'b1);
      check("lookup_taken", pred_taken, exp_t);
   endtask

   task automatic sweep_from(input int first);
      for (int i = first; i < 16; i++) begin
         idle();
         chk_wr("sweep_write", i[3:0], 2'd1);
         check("sweep_busy", busy, 1'b1);
      end
      idle();
      check("sweep_busy_fall", busy, 1'b0);
      check("sweep_ready_rise", upd_ready, 1'b1);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; lv = 1'b1; li = 4'd3; uv = 1'b0; ui = 4'd0; ut = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_tbl_quiet", {tbl_req, tbl_we, tbl_addr, tbl_wdata}, 8'd0);
      check("rst_pred_valid", pred_valid, 1'b0);
`ifdef BP_INIT_SWEEP_EN
      check("rst_busy", busy, 1'b1);
      check("rst_ready", upd_ready, 1'b0);
`else
      check("rst_busy", busy, 1'b0);
      check("rst_ready", upd_ready, 1'b1);
`endif
      @(negedge clk);
      rst = 1'b0; lv = 1'b0;
`ifdef BP_INIT_SWEEP_EN
      #1;
      chk_wr("sweep_write", 4'd0, 2'd1);
      sweep_from(1);
`endif

      // saturation up then floor down on entry 5
      do_update(4'd5, 1'b1, 2'd2);
      do_update(4'd5, 1'b1, 2'd3);
      do_update(4'd5, 1'b1, 2'd3);
      do_lookup(4'd5, 1'b1);
      do_update(4'd5, 1'b0, 2'd2);
      do_update(4'd5, 1'b0, 2'd1);
      do_update(4'd5, 1'b0, 2'd0);
      do_update(4'd5, 1'b0, 2'd0);
      do_lookup(4'd5, 1'b0);
      idle();
      check("pred_valid_drop", pred_valid, 1'b0);

      // lookups to 7 throughout an RMW on 7 defer the write
      drive(1'b0, 4'd0, 1'b1, 4'd7, 1'b1, 1'b0);
      idle();
      chk_rd("haz_pop", 4'd7);
      drive(1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 1'b0);
      chk_rd("haz_rd_lookup", 4'd7);
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 1'b0);
         chk_rd("haz_wr_hold", 4'd7);
         check("haz_old_taken", {pred_valid, pred_taken}, 2'b10);
      end
      idle();
      chk_wr("haz_deferred_write", 4'd7, 2'd2);
      check("haz_last_old", {pred_valid, pred_taken}, 2'b10);
      idle();
      check("haz_quiet", tbl_req, 1'b0);
      do_lookup(4'd7, 1'b1);

      // continuous lookups fill the FIFO; fifth update held then applied
      for (int k = 1; k <= 4; k++) begin
         drive(1'b1, 4'd0, 1'b1, k[3:0], 1'b1, 1'b0);
         check("starve_ready", upd_ready, 1'b1);
         chk_rd("starve_lookup", 4'd0);
      end
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 4'd0, 1'b1, 4'd6, 1'b1, 1'b0);
         check("starve_full", upd_ready, 1'b0);
      end
      drive(1'b0, 4'd0, 1'b1, 4'd6, 1'b1, 1'b0);
      check("full_pop_no_push", upd_ready, 1'b0);
      chk_rd("starve_pop1", 4'd1);
      drive(1'b0, 4'd0, 1'b1, 4'd6, 1'b1, 1'b0);
      check("starve_ready_back", upd_ready, 1'b1);
      chk_wr("starve_write1", 4'd1, 2'd2);
      for (int k = 0; k < 4; k++) begin
         logic [3:0] exp_idx;
         exp_idx = (k == 3) ? 4'd6 : 4'(k + 2);
         idle();
         chk_rd("drain_read", exp_idx);
         idle();
         chk_wr("drain_write", exp_idx, 2'd2);
      end
      idle();
      check("drain_empty", tbl_req, 1'b0);

      // flush in RD with two updates queued
      drive(1'b1, 4'd0, 1'b1, 4'd8, 1'b1, 1'b0);
      drive(1'b1, 4'd0, 1'b1, 4'd9, 1'b1, 1'b0);
      drive(1'b0, 4'd0, 1'b1, 4'd10, 1'b1, 1'b0);
      chk_rd("flush_pre_pop", 4'd8);
      drive(1'b0, 4'd0, 1'b1, 4'd12, 1'b1, 1'b1);
      check("flush_no_write", tbl_req, 1'b0);
`ifdef BP_INIT_SWEEP_EN
      idle();
      chk_wr("flush_sweep_start", 4'd0, 2'd1);
      sweep_from(1);
`else
      idle();
      check("flush_idle_busy", busy, 1'b0);
      check("flush_fifo_empty", tbl_req, 1'b0);
      idle();
      check("flush_fifo_empty2", tbl_req, 1'b0);
`endif
      do_lookup(4'd8, 1'b0);

`ifdef BP_INIT_SWEEP_EN
      // flush when the sweep reaches address 9 restarts it from 0
      drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, 4'd2, 1'b0, 4'd0, 1'b0, 1'b0);
         chk_wr("sweep_lookup_blocked", i[3:0], 2'd1);
      end
      drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
      check("flush9_no_write", tbl_req, 1'b0);
      check("sweep_pred_invalid", pred_valid, 1'b0);
      sweep_from(0);
`endif

      // reset asserted in RD: no write reaches the table
      drive(1'b0, 4'd0, 1'b1, 4'd11, 1'b1, 1'b0);
      idle();
      chk_rd("rst_mid_pop", 4'd11);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_mid_no_write", {tbl_req, tbl_we}, 2'b00);
      @(negedge clk);
      rst = 1'b0;
      #1;
`ifdef BP_INIT_SWEEP_EN
      chk_wr("rst_mid_sweep", 4'd0, 2'd1);
`else
      check("rst_mid_quiet", tbl_req, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
